// File: rtl/sobel_window_sched.sv
// Sequencing controller for a 3-line Sobel window: steers raster pixels into a
// ring of three line buffers and issues one padded kernel command per output pixel.
module sobel_window_sched #(
  parameter int IMAGE_WIDTH_E = 9,
  parameter int IMAGE_HIGHT_E = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  output logic                     wr_en,
  output logic [1:0]               wr_sel,
  output logic [IMAGE_WIDTH_E-1:0] wr_addr,
  output logic                     k_valid,
  input  logic                     k_ready,
  output logic [IMAGE_HIGHT_E-1:0] k_row,
  output logic [IMAGE_WIDTH_E-1:0] k_col,
  output logic [1:0]               k_top_sel,
  output logic [1:0]               k_mid_sel,
  output logic [1:0]               k_bot_sel,
  output logic [3:0]               k_pad,
  output logic                     k_last,
  output logic                     busy,
  output logic                     done
);

  localparam int IMAGE_WIDTH = 2 ** IMAGE_WIDTH_E;
  localparam int IMAGE_HIGHT = 2 ** IMAGE_HIGHT_E;
  localparam logic [IMAGE_WIDTH_E-1:0] COL_MAX = IMAGE_WIDTH_E'(IMAGE_WIDTH - 1);
  localparam logic [IMAGE_HIGHT_E-1:0] ROW_MAX = IMAGE_HIGHT_E'(IMAGE_HIGHT - 1);
  localparam logic [IMAGE_HIGHT_E-1:0] ROW_PEN = IMAGE_HIGHT_E'(IMAGE_HIGHT - 2);
  localparam logic [IMAGE_WIDTH_E-1:0] COL_ZERO = {IMAGE_WIDTH_E{1'b0}};
  localparam logic [IMAGE_HIGHT_E-1:0] ROW_ZERO = {IMAGE_HIGHT_E{1'b0}};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FILL = 3'd1,
    PROC = 3'd2,
    LOAD = 3'd3,
    DONE = 3'd4
  } state_t;

  // Ring phase advance: 0 -> 1 -> 2 -> 0, replaces a mod-3 divider.
  function automatic logic [1:0] rot3(input logic [1:0] p);
    case (p)
      2'd0:    rot3 = 2'd1;
      2'd1:    rot3 = 2'd2;
      default: rot3 = 2'd0;
    endcase
  endfunction

  state_t                   state, state_nx;
  logic [IMAGE_WIDTH_E-1:0] col, col_nx;
  logic [IMAGE_HIGHT_E-1:0] proc_row, proc_row_nx;
  logic [1:0]               load_ph, load_ph_nx;
  logic [1:0]               proc_ph, proc_ph_nx;
  logic                     px_acc, cmd_acc;

  assign px_acc  = s_valid & s_ready;
  assign cmd_acc = k_valid & k_ready;

  // Next-state and counter update logic.
  always_comb begin
    state_nx    = state;
    col_nx      = col;
    proc_row_nx = proc_row;
    load_ph_nx  = load_ph;
    proc_ph_nx  = proc_ph;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx    = FILL;
          col_nx      = COL_ZERO;
          proc_row_nx = ROW_ZERO;
          load_ph_nx  = 2'd0;
          proc_ph_nx  = 2'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      FILL, LOAD: begin
        if (px_acc && col == COL_MAX) begin
          col_nx     = COL_ZERO;
          load_ph_nx = rot3(load_ph);
          // FILL ends after line 1, LOAD after a single line
          if (state == LOAD || load_ph == 2'd1) begin
            state_nx = PROC;
          end else begin
            state_nx = state;
          end
        end else if (px_acc) begin
          col_nx = col + 1'b1;
        end else begin
          col_nx = col;
        end
      end
      PROC: begin
        if (cmd_acc && col == COL_MAX) begin
          col_nx      = COL_ZERO;
          proc_row_nx = proc_row + 1'b1;
          proc_ph_nx  = rot3(proc_ph);
          if (proc_row == ROW_MAX) begin
            state_nx = DONE;
          end else if (proc_row == ROW_PEN) begin
            state_nx = PROC;
          end else begin
            state_nx = LOAD;
          end
        end else if (cmd_acc) begin
          col_nx = col + 1'b1;
        end else begin
          col_nx = col;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State, counters and registered handshake/status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      col      <= COL_ZERO;
      proc_row <= ROW_ZERO;
      load_ph  <= 2'd0;
      proc_ph  <= 2'd0;
      s_ready  <= 1'b0;
      k_valid  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      col      <= col_nx;
      proc_row <= proc_row_nx;
      load_ph  <= load_ph_nx;
      proc_ph  <= proc_ph_nx;
      s_ready  <= (state_nx == FILL) || (state_nx == LOAD);
      k_valid  <= (state_nx == PROC);
      busy     <= (state_nx == FILL) || (state_nx == LOAD) || (state_nx == PROC);
      done     <= (state_nx == DONE);
    end
  end

  assign wr_en   = px_acc;
  assign wr_sel  = s_ready ? load_ph : 2'd0;
  assign wr_addr = s_ready ? col : COL_ZERO;

  // Command fields are forced to zero whenever no command is offered.
  assign k_row     = k_valid ? proc_row : ROW_ZERO;
  assign k_col     = k_valid ? col : COL_ZERO;
  assign k_mid_sel = k_valid ? proc_ph : 2'd0;
  assign k_bot_sel = k_valid ? rot3(proc_ph) : 2'd0;
  assign k_top_sel = k_valid ? rot3(rot3(proc_ph)) : 2'd0;
  assign k_pad     = k_valid ? {proc_row == ROW_ZERO, proc_row == ROW_MAX,
                                col == COL_ZERO, col == COL_MAX} : 4'b0000;
  assign k_last    = k_valid && (proc_row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: tb/tb_sobel_window_sched.sv
// Scoreboard bench for sobel_window_sched: a 4x4 and a 4x2 instance driven by
// a table of frame scenarios plus a hand-written mid-frame reset sequence.
module tb_sobel_window_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, start, s_valid, k_ready;
  int   sel_dut;
  logic start_a, start_b;
  assign start_a = start && (sel_dut == 0);
  assign start_b = start && (sel_dut == 1);

  logic a_s_ready, a_wr_en, a_k_valid, a_k_last, a_busy, a_done;
  logic [1:0] a_wr_sel, a_wr_addr, a_k_row, a_k_col, a_top, a_mid, a_bot;
  logic [3:0] a_k_pad;
  logic b_s_ready, b_wr_en, b_k_valid, b_k_last, b_busy, b_done;
  logic [1:0] b_wr_sel, b_wr_addr, b_k_col, b_top, b_mid, b_bot;
  logic [0:0] b_k_row;
  logic [3:0] b_k_pad;

  sobel_window_sched #(.IMAGE_WIDTH_E(2), .IMAGE_HIGHT_E(2)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .s_valid(s_valid), .s_ready(a_s_ready),
    .wr_en(a_wr_en), .wr_sel(a_wr_sel), .wr_addr(a_wr_addr), .k_valid(a_k_valid),
    .k_ready(k_ready), .k_row(a_k_row), .k_col(a_k_col), .k_top_sel(a_top),
    .k_mid_sel(a_mid), .k_bot_sel(a_bot), .k_pad(a_k_pad), .k_last(a_k_last),
    .busy(a_busy), .done(a_done));

  sobel_window_sched #(.IMAGE_WIDTH_E(2), .IMAGE_HIGHT_E(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .s_valid(s_valid), .s_ready(b_s_ready),
    .wr_en(b_wr_en), .wr_sel(b_wr_sel), .wr_addr(b_wr_addr), .k_valid(b_k_valid),
    .k_ready(k_ready), .k_row(b_k_row), .k_col(b_k_col), .k_top_sel(b_top),
    .k_mid_sel(b_mid), .k_bot_sel(b_bot), .k_pad(b_k_pad), .k_last(b_k_last),
    .busy(b_busy), .done(b_done));

  logic [23:0] a_all;
  logic [22:0] b_all;
  assign a_all = {a_s_ready, a_wr_en, a_wr_sel, a_wr_addr, a_k_valid, a_k_row, a_k_col,
                  a_top, a_mid, a_bot, a_k_pad, a_k_last, a_busy, a_done};
  assign b_all = {b_s_ready, b_wr_en, b_wr_sel, b_wr_addr, b_k_valid, b_k_row, b_k_col,
                  b_top, b_mid, b_bot, b_k_pad, b_k_last, b_busy, b_done};

  logic m_s_ready, m_wr_en, m_k_valid, m_k_last, m_busy, m_done;
  logic [1:0] m_wr_sel, m_wr_addr, m_k_row, m_k_col, m_top, m_mid, m_bot;
  logic [3:0] m_k_pad;

  // Present the selected instance's outputs on one set of names.
  always_comb begin
    if (sel_dut == 0) begin
      m_s_ready = a_s_ready; m_wr_en = a_wr_en; m_wr_sel = a_wr_sel; m_wr_addr = a_wr_addr;
      m_k_valid = a_k_valid; m_k_row = a_k_row; m_k_col = a_k_col; m_top = a_top;
      m_mid = a_mid; m_bot = a_bot; m_k_pad = a_k_pad; m_k_last = a_k_last;
      m_busy = a_busy; m_done = a_done;
    end else begin
      m_s_ready = b_s_ready; m_wr_en = b_wr_en; m_wr_sel = b_wr_sel; m_wr_addr = b_wr_addr;
      m_k_valid = b_k_valid; m_k_row = {1'b0, b_k_row}; m_k_col = b_k_col; m_top = b_top;
      m_mid = b_mid; m_bot = b_bot; m_k_pad = b_k_pad; m_k_last = b_k_last;
      m_busy = b_busy; m_done = b_done;
    end
  end

  typedef struct { int dut; int sv_pct; int kr_pct; int poke; int w; int h; } frame_t;
  typedef struct { int sel; int addr; int need; } wr_t;
  typedef struct { int row; int col; int top; int mid; int bot; int pad; int last; } cmd_t;

  int     checks = 0;
  int     failures = 0;
  wr_t    wq[$];
  cmd_t   cq[$];
  frame_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build_expect(input int w, input int h);
    wr_t  ew;
    cmd_t ec;
    wq.delete();
    cq.delete();
    for (int l = 0; l < h; l++) begin
      for (int c = 0; c < w; c++) begin
        ew.sel = l % 3; ew.addr = c; ew.need = (l < 2) ? 0 : (l - 1) * w;
        wq.push_back(ew);
      end
    end
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        ec.row = r; ec.col = c;
        ec.top = (r + 2) % 3; ec.mid = r % 3; ec.bot = (r + 1) % 3;
        ec.pad = ((r == 0) ? 8 : 0) + ((r == h - 1) ? 4 : 0) + ((c == 0) ? 2 : 0) + ((c == w - 1) ? 1 : 0);
        ec.last = (r == h - 1 && c == w - 1) ? 1 : 0;
        cq.push_back(ec);
      end
    end
  endtask

  task automatic run_frame(input frame_t f);
    wr_t  ew;
    cmd_t ec;
    int   writes = 0, cmds = 0, dones = 0, busy_cyc = 0, post = 0;
    int   h_row = 0, h_col = 0, h_pad = 0;
    bit   seen = 0, stalled = 0, ok_end = 0;
    sel_dut = f.dut;
    build_expect(f.w, f.h);
    @(negedge clk);
    s_valid = 1'b0; k_ready = 1'b0;
    #1 check("idle_busy", int'(m_busy), 0);
    start = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      start   = (f.poke != 0 && cyc == 5);
      s_valid = (int'($urandom_range(0, 99)) < f.sv_pct);
      k_ready = (int'($urandom_range(0, 99)) < f.kr_pct);
      #1;
      if (m_s_ready && m_k_valid) check("ready_valid_excl", 1, 0);
      if (m_wr_en) begin
        if (wq.size() == 0) check("extra_write", 1, 0);
        else begin
          ew = wq.pop_front();
          check("wr_sel", int'(m_wr_sel), ew.sel);
          check("wr_addr", int'(m_wr_addr), ew.addr);
          check("wr_after_cmds", cmds, ew.need);
          writes++;
        end
      end
      if (m_k_valid && stalled) begin
        check("hold_row", int'(m_k_row), h_row);
        check("hold_col", int'(m_k_col), h_col);
        check("hold_pad", int'(m_k_pad), h_pad);
      end
      stalled = m_k_valid && !k_ready;
      h_row = int'(m_k_row); h_col = int'(m_k_col); h_pad = int'(m_k_pad);
      if (m_k_valid && k_ready) begin
        if (cq.size() == 0) check("extra_cmd", 1, 0);
        else begin
          ec = cq.pop_front();
          check("k_row", int'(m_k_row), ec.row);
          check("k_col", int'(m_k_col), ec.col);
          check("k_top_sel", int'(m_top), ec.top);
          check("k_mid_sel", int'(m_mid), ec.mid);
          check("k_bot_sel", int'(m_bot), ec.bot);
          check("k_pad", int'(m_k_pad), ec.pad);
          check("k_last", int'(m_k_last), ec.last);
          cmds++;
        end
      end
      if (m_busy) busy_cyc++;
      if (seen) begin
        post++;
        check("post_idle_busy", int'(m_busy), 0);
      end
      if (m_done) begin
        dones++;
        seen = 1;
        check("done_busy", int'(m_busy), 0);
        if (f.poke != 0) start = 1'b1;
      end
      if (post >= 4) begin
        ok_end = 1;
        break;
      end
    end
    start = 1'b0; s_valid = 1'b0; k_ready = 1'b0;
    check("frame_end", int'(ok_end), 1);
    check("write_total", writes, f.w * f.h);
    check("cmd_total", cmds, f.w * f.h);
    check("done_pulses", dones, 1);
    check("queues_empty", wq.size() + cq.size(), 0);
    if (f.sv_pct == 100 && f.kr_pct == 100 && f.poke == 0)
      check("frame_time_ok", int'(busy_cyc <= 2 * f.w * f.h + f.h + 2), 1);
  endtask

  task automatic reset_mid_load();
    int wc = 0, kc = 0;
    bit hit = 0;
    sel_dut = 0;
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      start = 1'b0; s_valid = 1'b1; k_ready = 1'b1;
      #1;
      if (m_wr_en) wc++;
      if (m_k_valid) kc++;
      if (wc == 10) begin
        hit = 1;
        break;
      end
    end
    check("rst_reach_load", int'(hit), 1);
    check("rst_in_load", int'(m_s_ready), 1);
    check("rst_row0_cmds", kc, 4);
    reset = 1'b1;
    #1 check("rst_async_zero", int'(a_all), 0);
    repeat (3) begin
      @(negedge clk);
      #1 check("rst_no_done", int'(m_done), 0);
    end
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; k_ready = 1'b0;
    #1 check("rst_idle", int'(a_all), 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; s_valid = 1'b0; k_ready = 1'b0; sel_dut = 0;
    tbl[0] = '{0, 100, 100, 0, 4, 4};
    tbl[1] = '{0, 100,  50, 0, 4, 4};
    tbl[2] = '{0,  60, 100, 0, 4, 4};
    tbl[3] = '{0,  60,  50, 1, 4, 4};
    tbl[4] = '{1, 100, 100, 0, 4, 2};
    tbl[5] = '{1,  70,  60, 1, 4, 2};
    #12;
    check("reset_a_zero", int'(a_all), 0);
    check("reset_b_zero", int'(b_all), 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) run_frame(tbl[i]);
    reset_mid_load();
    run_frame(tbl[0]);
    run_frame(tbl[3]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
